dpwm_capture: RTL and testbench

Measures the complementary gate pair produced by the team's deadtime DPWM and recovers per-switching-cycle timing: high-side on-time, leading deadtime, low-side on-time, trailing deadtime and period, in clk cycles. Raises sticky faults on shoot-through, illegal sequencing and missing edges. It sits on the gate-drive outputs, in the same clk domain, and feeds the loop supervisor and the verification scoreboard.

---
 rtl/dpwm_capture.sv | 231 +++++++++++++++++++++++
 tb/tb_dpwm_capture.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpwm_capture.sv
// Per-cycle timing recovery for a complementary deadtime gate pair:
// high on-time, leading deadtime, low on-time, trailing deadtime and period.
module dpwm_capture #(
    parameter int unsigned CW      = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          gate_high,
    input  logic          gate_low,
    input  logic          clr_flags,
    output logic [CW-1:0] t_high,
    output logic [CW-1:0] t_dt1,
    output logic [CW-1:0] t_low,
    output logic [CW-1:0] t_dt2,
    output logic [CW+1:0] t_period,
    output logic          meas_valid,
    output logic          flag_overlap,
    output logic          flag_seq_err,
    output logic          flag_timeout
);

    localparam int unsigned   PW      = CW + 2;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_PRE  = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        WAIT = 3'd0,
        HIGH = 3'd1,
        DT1  = 3'd2,
        LOW  = 3'd3,
        DT2  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          s_hi;
    logic          s_lo;
    logic          s_hi_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] w_high;
    logic [CW-1:0] w_dt1;
    logic [CW-1:0] w_low;

    logic          rise_c;
    logic          timeout_c;
    logic          done_c;
    logic          cap_high_c;
    logic          cap_dt1_c;
    logic          cap_low_c;
    logic          zero_dt1_c;
    logic          set_ovl_c;
    logic          set_seq_c;
    logic          set_to_c;
    logic [CW-1:0] c_dt1;
    logic [CW-1:0] c_low;
    logic [CW-1:0] c_dt2;

    // Input samples; high-side resets high so a gate already on at release is not a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_hi   <= 1'b1;
            s_hi_d <= 1'b1;
            s_lo   <= 1'b0;
        end else begin
            s_hi   <= gate_high;
            s_hi_d <= s_hi;
            s_lo   <= gate_low;
        end
    end

    // State and phase counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sequencing, phase captures and fault detection.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        done_c     = 1'b0;
        cap_high_c = 1'b0;
        cap_dt1_c  = 1'b0;
        cap_low_c  = 1'b0;
        zero_dt1_c = 1'b0;
        set_ovl_c  = 1'b0;
        set_seq_c  = 1'b0;
        set_to_c   = 1'b0;
        c_dt1      = w_dt1;
        c_low      = w_low;
        c_dt2      = '0;
        rise_c     = s_hi && !s_hi_d;
        timeout_c  = (state != WAIT) && (cnt == TO_VAL);

        if (s_hi && s_lo) begin
            set_ovl_c = 1'b1;
            state_nxt = WAIT;
        end else if (timeout_c) begin
            set_to_c  = 1'b1;
            state_nxt = WAIT;
        end else begin
            case (state)
                WAIT: begin
                    if (rise_c && !s_lo) begin
                        state_nxt = HIGH;
                    end else if (cnt == TO_PRE) begin
                        set_to_c = 1'b1;
                    end
                end
                HIGH: begin
                    if (!s_hi) begin
                        cap_high_c = 1'b1;
                        if (s_lo) begin
                            zero_dt1_c = 1'b1;
                            state_nxt  = LOW;
                        end else begin
                            state_nxt  = DT1;
                        end
                    end
                end
                DT1: begin
                    if (s_lo) begin
                        cap_dt1_c = 1'b1;
                        state_nxt = LOW;
                    end else if (s_hi) begin
                        done_c    = 1'b1;
                        c_dt1     = cnt;
                        c_low     = '0;
                        state_nxt = HIGH;
                    end
                end
                LOW: begin
                    if (!s_lo) begin
                        if (s_hi) begin
                            done_c    = 1'b1;
                            c_low     = cnt;
                            state_nxt = HIGH;
                        end else begin
                            cap_low_c = 1'b1;
                            state_nxt = DT2;
                        end
                    end
                end
                DT2: begin
                    if (s_hi) begin
                        done_c    = 1'b1;
                        c_dt2     = cnt;
                        state_nxt = HIGH;
                    end else if (s_lo) begin
                        set_seq_c = 1'b1;
                        state_nxt = WAIT;
                    end
                end
                default: state_nxt = WAIT;
            endcase
        end

        // Idle WAIT parks at TIMEOUT; every phase saturates at the counter ceiling.
        if (state_nxt != state) begin
            cnt_nxt = CW'(1);
        end else if ((state == WAIT) && (cnt >= TO_VAL)) begin
            cnt_nxt = cnt;
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // Working captures for the cycle in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_high <= '0;
            w_dt1  <= '0;
            w_low  <= '0;
        end else begin
            if (cap_high_c) begin
                w_high <= cnt;
            end
            if (zero_dt1_c) begin
                w_dt1 <= '0;
            end else if (cap_dt1_c) begin
                w_dt1 <= cnt;
            end
            if (cap_low_c) begin
                w_low <= cnt;
            end
        end
    end

    // Published measurement, updated atomically at cycle completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_high     <= '0;
            t_dt1      <= '0;
            t_low      <= '0;
            t_dt2      <= '0;
            t_period   <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= done_c;
            if (done_c) begin
                t_high   <= w_high;
                t_dt1    <= c_dt1;
                t_low    <= c_low;
                t_dt2    <= c_dt2;
                t_period <= PW'(w_high) + PW'(c_dt1) + PW'(c_low) + PW'(c_dt2);
            end
        end
    end

    // Sticky flags; a new fault wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_overlap <= 1'b0;
            flag_seq_err <= 1'b0;
            flag_timeout <= 1'b0;
        end else begin
            flag_overlap <= set_ovl_c | (flag_overlap & ~clr_flags);
            flag_seq_err <= set_seq_c | (flag_seq_err & ~clr_flags);
            flag_timeout <= set_to_c  | (flag_timeout & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_dpwm_capture.sv
// Scoreboard bench for dpwm_capture: expected cycles queued as gates are driven,
// popped and compared on every meas_valid pulse.
module tb_dpwm_capture;

    localparam int unsigned CW      = 8;
    localparam int unsigned TIMEOUT = 200;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          gate_high;
    logic          gate_low;
    logic          clr_flags;
    logic [CW-1:0] t_high;
    logic [CW-1:0] t_dt1;
    logic [CW-1:0] t_low;
    logic [CW-1:0] t_dt2;
    logic [CW+1:0] t_period;
    logic          meas_valid;
    logic          flag_overlap;
    logic          flag_seq_err;
    logic          flag_timeout;

    typedef struct {
        int h;
        int d1;
        int l;
        int d2;
        int p;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   n_pulse    = 0;
    int   cyc        = 0;
    int   last_pulse = 0;
    int   last_gap   = 0;

    dpwm_capture #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gate_high    (gate_high),
        .gate_low     (gate_low),
        .clr_flags    (clr_flags),
        .t_high       (t_high),
        .t_dt1        (t_dt1),
        .t_low        (t_low),
        .t_dt2        (t_dt2),
        .t_period     (t_period),
        .meas_valid   (meas_valid),
        .flag_overlap (flag_overlap),
        .flag_seq_err (flag_seq_err),
        .flag_timeout (flag_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            n_pulse++;
            last_gap   = cyc - last_pulse;
            last_pulse = cyc;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_meas_valid: pulse at cycle %0d, required none", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (t_high !== CW'(mon_e.h) || t_dt1 !== CW'(mon_e.d1) || t_low !== CW'(mon_e.l) ||
                    t_dt2 !== CW'(mon_e.d2) || t_period !== (CW+2)'(mon_e.p)) begin
                    n_bad++;
                    $display("FAIL measurement: got h=%0d d1=%0d l=%0d d2=%0d p=%0d, required h=%0d d1=%0d l=%0d d2=%0d p=%0d",
                             t_high, t_dt1, t_low, t_dt2, t_period,
                             mon_e.h, mon_e.d1, mon_e.l, mon_e.d2, mon_e.p);
                end
            end
        end
    end

    task automatic hold(input logic h, input logic l, input int n);
        if (n <= 0) return;
        gate_high = h;
        gate_low  = l;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_cycle(input int h, input int d1, input int l, input int d2, input bit push);
        exp_t e;
        if (push) begin
            e = '{h, d1, l, d2, h + d1 + l + d2};
            sb.push_back(e);
        end
        hold(1'b1, 1'b0, h);
        hold(1'b0, 1'b0, d1);
        hold(1'b0, 1'b1, l);
        hold(1'b0, 1'b0, d2);
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        gate_high = 1'b0;
        gate_low  = 1'b0;
        clr_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({t_high, t_dt1, t_low, t_dt2, t_period, meas_valid} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got h=%0d d1=%0d l=%0d d2=%0d p=%0d v=%0b, required all 0",
                     t_high, t_dt1, t_low, t_dt2, t_period, meas_valid);
        end
        n_cmp++;
        if ({flag_overlap, flag_seq_err, flag_timeout} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, required 000", {flag_overlap, flag_seq_err, flag_timeout});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_standard();
        int p0;
        exp_t e;
        hold(1'b0, 1'b0, 2);
        p0 = n_pulse;
        drive_cycle(20, 6, 32, 6, 1'b1);
        e = '{20, 6, 32, 6, 64};
        sb.push_back(e);
        gate_high = 1'b1;
        gate_low  = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (meas_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: got meas_valid=%0b, required 0", meas_valid);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (meas_valid !== 1'b1 || t_period !== 10'd64) begin
            n_bad++;
            $display("FAIL latency_edge: got meas_valid=%0b t_period=%0d, required 1 and 64", meas_valid, t_period);
        end
        hold(1'b1, 1'b0, 18);
        hold(1'b0, 1'b0, 6);
        hold(1'b0, 1'b1, 32);
        hold(1'b0, 1'b0, 6);
        repeat (3) drive_cycle(20, 6, 32, 6, 1'b1);
        n_cmp++;
        if (n_pulse - p0 != 4) begin
            n_bad++;
            $display("FAIL standard_pulses: got %0d, required 4", n_pulse - p0);
        end
        n_cmp++;
        if (last_gap != 64) begin
            n_bad++;
            $display("FAIL standard_gap: got %0d, required 64", last_gap);
        end
        n_cmp++;
        if ({flag_overlap, flag_seq_err, flag_timeout} !== 3'b000) begin
            n_bad++;
            $display("FAIL standard_flags: got %b, required 000", {flag_overlap, flag_seq_err, flag_timeout});
        end
    endtask

    task automatic test_no_low();
        repeat (3) drive_cycle(54, 10, 0, 0, 1'b1);
        n_cmp++;
        if (last_gap != 64) begin
            n_bad++;
            $display("FAIL no_low_gap: got %0d, required 64", last_gap);
        end
        n_cmp++;
        if (t_low !== '0 || t_dt2 !== '0) begin
            n_bad++;
            $display("FAIL no_low_zero: got t_low=%0d t_dt2=%0d, required 0 and 0", t_low, t_dt2);
        end
    endtask

    task automatic test_zero_dt();
        repeat (3) drive_cycle(30, 0, 34, 0, 1'b1);
        n_cmp++;
        if (flag_seq_err !== 1'b0 || flag_overlap !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_dt_flags: got seq=%0b ovl=%0b, required 0 and 0", flag_seq_err, flag_overlap);
        end
        n_cmp++;
        if (last_gap != 64) begin
            n_bad++;
            $display("FAIL zero_dt_gap: got %0d, required 64", last_gap);
        end
    endtask

    task automatic test_overlap();
        int p0;
        hold(1'b1, 1'b0, 10);
        p0 = n_pulse;
        hold(1'b1, 1'b1, 1);
        n_cmp++;
        if (flag_overlap !== 1'b0) begin
            n_bad++;
            $display("FAIL overlap_early: got %0b, required 0", flag_overlap);
        end
        hold(1'b1, 1'b0, 1);
        n_cmp++;
        if (flag_overlap !== 1'b1) begin
            n_bad++;
            $display("FAIL overlap_set: got %0b, required 1", flag_overlap);
        end
        hold(1'b1, 1'b0, 8);
        hold(1'b0, 1'b0, 6);
        hold(1'b0, 1'b1, 32);
        hold(1'b0, 1'b0, 6);
        n_cmp++;
        if (n_pulse != p0) begin
            n_bad++;
            $display("FAIL overlap_no_valid: got %0d pulses, required 0", n_pulse - p0);
        end
        pulse_clr();
        n_cmp++;
        if (flag_overlap !== 1'b0) begin
            n_bad++;
            $display("FAIL overlap_clear: got %0b, required 0", flag_overlap);
        end
        drive_cycle(20, 6, 32, 6, 1'b1);
        drive_cycle(20, 6, 32, 6, 1'b1);
        n_cmp++;
        if (n_pulse - p0 != 1) begin
            n_bad++;
            $display("FAIL overlap_recover: got %0d pulses, required 1", n_pulse - p0);
        end
    endtask

    task automatic test_seq_err();
        int p0;
        hold(1'b1, 1'b0, 20);
        p0 = n_pulse;
        hold(1'b0, 1'b0, 6);
        hold(1'b0, 1'b1, 32);
        hold(1'b0, 1'b0, 3);
        hold(1'b0, 1'b1, 5);
        n_cmp++;
        if (flag_seq_err !== 1'b1) begin
            n_bad++;
            $display("FAIL seq_err_set: got %0b, required 1", flag_seq_err);
        end
        hold(1'b0, 1'b0, 3);
        pulse_clr();
        n_cmp++;
        if (flag_seq_err !== 1'b0) begin
            n_bad++;
            $display("FAIL seq_err_clear: got %0b, required 0", flag_seq_err);
        end
        drive_cycle(20, 6, 32, 6, 1'b1);
        drive_cycle(20, 6, 32, 6, 1'b1);
        n_cmp++;
        if (n_pulse - p0 != 1) begin
            n_bad++;
            $display("FAIL seq_err_recover: got %0d pulses, required 1", n_pulse - p0);
        end
    endtask

    task automatic test_timeout();
        int p0;
        hold(1'b1, 1'b0, 150);
        n_cmp++;
        if (flag_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early: got %0b, required 0", flag_timeout);
        end
        p0 = n_pulse;
        hold(1'b1, 1'b0, 100);
        n_cmp++;
        if (flag_timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_set: got %0b, required 1", flag_timeout);
        end
        hold(1'b0, 1'b0, 6);
        drive_cycle(20, 6, 32, 6, 1'b1);
        drive_cycle(20, 6, 32, 6, 1'b1);
        n_cmp++;
        if (n_pulse - p0 != 1) begin
            n_bad++;
            $display("FAIL timeout_recover: got %0d pulses, required 1", n_pulse - p0);
        end
    endtask

    task automatic test_reset_high();
        int p0;
        hold(1'b1, 1'b0, 5);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({t_high, t_dt1, t_low, t_dt2, t_period, meas_valid, flag_overlap, flag_seq_err, flag_timeout} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got h=%0d p=%0d v=%0b flags=%b, required all 0",
                     t_high, t_period, meas_valid, {flag_overlap, flag_seq_err, flag_timeout});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        p0 = n_pulse;
        hold(1'b1, 1'b0, 15);
        hold(1'b0, 1'b0, 6);
        hold(1'b0, 1'b1, 32);
        hold(1'b0, 1'b0, 6);
        drive_cycle(20, 6, 32, 6, 1'b1);
        n_cmp++;
        if (n_pulse != p0) begin
            n_bad++;
            $display("FAIL no_false_rise: got %0d pulses, required 0", n_pulse - p0);
        end
        drive_cycle(20, 6, 32, 6, 1'b1);
        hold(1'b1, 1'b0, 3);
        n_cmp++;
        if (n_pulse - p0 != 2) begin
            n_bad++;
            $display("FAIL reset_recover: got %0d pulses, required 2", n_pulse - p0);
        end
    endtask

    initial begin
        test_reset();
        test_standard();
        test_no_low();
        test_zero_dt();
        test_overlap();
        test_seq_err();
        test_timeout();
        test_reset_high();
        hold(1'b0, 1'b0, 4);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
